// File: rtl/pc_seq_pkg.sv
// -----------------------------------------------------------------------------
// pc_seq_pkg
// Purpose : Shared definitions for the PC sequencer block: the branch-mode
//           encoding driven by the control unit and its field width.
// Ports   : (package, no ports)
// -----------------------------------------------------------------------------
package pc_seq_pkg;

  localparam int BR_MODE_W = 3;

  // Branch-mode encoding; codes 6 and 7 are unused and behave as BR_NONE.
  typedef enum logic [BR_MODE_W-1:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_J    = 3'd3,
    BR_CALL = 3'd4,
    BR_RET  = 3'd5
  } brMode_e;

endpackage

// File: rtl/pc_ras.sv
// -----------------------------------------------------------------------------
// pc_ras
// Purpose : Circular return-address stack. A push when full overwrites the
//           oldest entry, so later pops only see the newest RAS_DEPTH values.
// Ports   : CLK       - clock, rising edge
//           RESET     - synchronous active-high reset (pointer/count only)
//           push      - write push_data on top of stack
//           pop       - discard top of stack (ignored when empty)
//           push_data - return address to store
//           top       - most recently pushed valid entry
//           count     - number of valid entries (0..RAS_DEPTH)
//           empty     - count == 0
//           full      - count == RAS_DEPTH
// -----------------------------------------------------------------------------
module pc_ras #(
  parameter int PC_WIDTH  = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_WIDTH-1:0]          push_data,
  output logic [PC_WIDTH-1:0]          top,
  output logic [$clog2(RAS_DEPTH):0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_WIDTH-1:0] r_stack [RAS_DEPTH];
  logic [PTR_W-1:0]    r_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [PTR_W-1:0]    w_topIdx;

  // The pointer names the next free slot; the top is the slot just below it.
  // Power-of-two depth lets the pointer wrap naturally onto the oldest entry.
  assign w_topIdx = r_ptr - PTR_W'(1);
  assign top      = r_stack[w_topIdx];
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_W'(RAS_DEPTH));

  // Storage array carries no reset: entries are only visible through count.
  always_ff @(posedge CLK) begin
    if (push) begin
      r_stack[r_ptr] <= push_data;
    end
  end

  // Pointer and occupancy; count saturates at RAS_DEPTH on overwrite.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!full) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      r_ptr   <= w_topIdx;
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Purpose : Registered program counter with next-PC selection for sequential
//           flow, BEQ, BNE, J, CALL and RET, backed by a return-address stack.
//           Everything holds while busywait is high; RESET overrides all.
// Ports   : CLK           - clock, rising edge
//           RESET         - synchronous active-high reset
//           busywait      - memory stall, freezes all state
//           br_mode       - branch mode (see pc_seq_pkg)
//           zero          - ALU zero flag for BEQ/BNE
//           offset        - signed word offset
//           pc            - current PC
//           pc_plus4      - pc + 4
//           redirect      - one cycle after a non-sequential PC load
//           ras_count     - valid RAS entries
//           ras_overflow  - sticky, CALL with RAS full
//           ras_underflow - sticky, RET with RAS empty
// -----------------------------------------------------------------------------
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                   PC_WIDTH     = 32,
  parameter int                   OFFSET_WIDTH = 8,
  parameter int                   RAS_DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         busywait,
  input  logic [BR_MODE_W-1:0]         br_mode,
  input  logic                         zero,
  input  logic [OFFSET_WIDTH-1:0]      offset,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [PC_WIDTH-1:0]          pc_plus4,
  output logic                         redirect,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_redirect;
  logic                r_overflow;
  logic                r_underflow;

  logic [PC_WIDTH-1:0] w_pcPlus4;
  logic [PC_WIDTH-1:0] w_offsetExt;
  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_nextPc;
  logic [PC_WIDTH-1:0] w_rasTop;
  logic                w_taken;
  logic                w_callReq;
  logic                w_retReq;
  logic                w_underflowEvt;
  logic                w_advance;
  logic                w_push;
  logic                w_pop;
  logic                w_rasEmpty;
  logic                w_rasFull;

  // Word offset is sign-extended then scaled to bytes; all sums wrap silently.
  assign w_pcPlus4   = r_pc + PC_WIDTH'(4);
  assign w_offsetExt = {{(PC_WIDTH-OFFSET_WIDTH){offset[OFFSET_WIDTH-1]}}, offset};
  assign w_target    = w_pcPlus4 + (w_offsetExt << 2);
  assign w_advance   = !busywait;
  assign w_push      = w_callReq && w_advance;
  assign w_pop       = w_retReq && w_advance;

  // Next-PC selection. w_taken marks any load that is not pc+4, which is
  // exactly what redirect reports on the following cycle.
  always_comb begin
    w_nextPc       = w_pcPlus4;
    w_taken        = 1'b0;
    w_callReq      = 1'b0;
    w_retReq       = 1'b0;
    w_underflowEvt = 1'b0;
    case (br_mode)
      BR_BEQ: begin
        if (zero) begin
          w_nextPc = w_target;
          w_taken  = 1'b1;
        end
      end
      BR_BNE: begin
        if (!zero) begin
          w_nextPc = w_target;
          w_taken  = 1'b1;
        end
      end
      BR_J: begin
        w_nextPc = w_target;
        w_taken  = 1'b1;
      end
      BR_CALL: begin
        w_nextPc  = w_target;
        w_taken   = 1'b1;
        w_callReq = 1'b1;
      end
      BR_RET: begin
        if (!w_rasEmpty) begin
          w_nextPc = w_rasTop;
          w_taken  = 1'b1;
          w_retReq = 1'b1;
        end else begin
          w_underflowEvt = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Return-address stack; push/pop are already gated by the stall.
  pc_ras #(
    .PC_WIDTH  (PC_WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .CLK       (CLK),
    .RESET     (RESET),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pcPlus4),
    .top       (w_rasTop),
    .count     (ras_count),
    .empty     (w_rasEmpty),
    .full      (w_rasFull)
  );

  // PC, redirect and sticky flags advance together only when not stalled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc        <= RESET_VECTOR;
      r_redirect  <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (w_advance) begin
      r_pc       <= w_nextPc;
      r_redirect <= w_taken;
      if (w_push && w_rasFull) begin
        r_overflow <= 1'b1;
      end
      if (w_underflowEvt) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign pc            = r_pc;
  assign pc_plus4      = w_pcPlus4;
  assign redirect      = r_redirect;
  assign ras_overflow  = r_overflow;
  assign ras_underflow = r_underflow;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Purpose : Self-checking bench for pc_sequencer with the default parameters.
//           Directed vectors push their hand-computed expected state into a
//           queue; a monitor pops one entry after each rising edge and checks.
// Ports   : (testbench, no ports)
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic        redirect;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;
  } expect_t;

  logic        CLK;
  logic        RESET;
  logic        busywait;
  logic [2:0]  br_mode;
  logic        zero;
  logic [7:0]  offset;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [2:0]  ras_count;
  logic        ras_overflow;
  logic        ras_underflow;

  expect_t expQ[$];
  string   nameQ[$];
  int      checks = 0;
  int      errors = 0;

  pc_sequencer #(
    .PC_WIDTH     (32),
    .OFFSET_WIDTH (8),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (32'h0)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .busywait      (busywait),
    .br_mode       (br_mode),
    .zero          (zero),
    .offset        (offset),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .redirect      (redirect),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // One comparison: counts it and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the state the
  // DUT must show after the next rising edge.
  task automatic applyStimulus(input string name, input logic rst, input logic busy,
                               input logic [2:0] mode, input logic z,
                               input logic [7:0] off, input logic [31:0] ePc,
                               input logic eRed, input logic [2:0] eCnt,
                               input logic eOv, input logic eUn);
    expect_t e;
    @(negedge CLK);
    RESET    = rst;
    busywait = busy;
    br_mode  = mode;
    zero     = z;
    offset   = off;
    e.pc        = ePc;
    e.redirect  = eRed;
    e.count     = eCnt;
    e.overflow  = eOv;
    e.underflow = eUn;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Monitor: one expected entry is consumed shortly after every rising edge.
  always @(posedge CLK) begin
    expect_t     e;
    string       n;
    logic [31:0] expPlus4;
    #1;
    if (expQ.size() != 0) begin
      e = expQ.pop_front();
      n = nameQ.pop_front();
      expPlus4 = e.pc + 32'd4;
      checkOutput({n, ".pc"},        pc,                     e.pc);
      checkOutput({n, ".pc_plus4"},  pc_plus4,               expPlus4);
      checkOutput({n, ".redirect"},  {31'd0, redirect},      {31'd0, e.redirect});
      checkOutput({n, ".ras_count"}, {29'd0, ras_count},     {29'd0, e.count});
      checkOutput({n, ".overflow"},  {31'd0, ras_overflow},  {31'd0, e.overflow});
      checkOutput({n, ".underflow"}, {31'd0, ras_underflow}, {31'd0, e.underflow});
    end
  end

  // Directed sequence; each row lists the state expected after its edge.
  initial begin
    RESET    = 1'b1;
    busywait = 1'b0;
    br_mode  = BR_NONE;
    zero     = 1'b0;
    offset   = 8'h00;

    // Sequential flow after reset
    applyStimulus("reset0", 1, 0, BR_NONE, 0, 8'h00, 32'h0, 0, 0, 0, 0);
    applyStimulus("seq1",   0, 0, BR_NONE, 0, 8'h00, 32'h4, 0, 0, 0, 0);
    applyStimulus("seq2",   0, 0, BR_NONE, 0, 8'h00, 32'h8, 0, 0, 0, 0);
    applyStimulus("seq3",   0, 0, BR_NONE, 0, 8'h00, 32'hC, 0, 0, 0, 0);

    // Conditional branches from 0x8
    applyStimulus("reset1",   1, 0, BR_NONE, 0, 8'h00, 32'h0,  0, 0, 0, 0);
    applyStimulus("seq4",     0, 0, BR_NONE, 0, 8'h00, 32'h4,  0, 0, 0, 0);
    applyStimulus("seq5",     0, 0, BR_NONE, 0, 8'h00, 32'h8,  0, 0, 0, 0);
    applyStimulus("beqTaken", 0, 0, BR_BEQ,  1, 8'hFE, 32'h4,  1, 0, 0, 0);
    applyStimulus("seq6",     0, 0, BR_NONE, 0, 8'h00, 32'h8,  0, 0, 0, 0);
    applyStimulus("beqNot",   0, 0, BR_BEQ,  0, 8'hFE, 32'hC,  0, 0, 0, 0);
    applyStimulus("jBack",    0, 0, BR_J,    0, 8'hFE, 32'h8,  1, 0, 0, 0);
    applyStimulus("bneTaken", 0, 0, BR_BNE,  0, 8'h02, 32'h14, 1, 0, 0, 0);
    applyStimulus("jBack2",   0, 0, BR_J,    0, 8'hFC, 32'h8,  1, 0, 0, 0);
    applyStimulus("bneNot",   0, 0, BR_BNE,  1, 8'h05, 32'hC,  0, 0, 0, 0);

    // Stall holds a pending jump, then it completes
    for (int i = 0; i < 3; i++) begin
      applyStimulus($sformatf("stall%0d", i), 0, 1, BR_J, 0, 8'h03, 32'hC, 0, 0, 0, 0);
    end
    applyStimulus("jRelease", 0, 0, BR_J, 0, 8'h03, 32'h1C, 1, 0, 0, 0);
    applyStimulus("mode7",    0, 0, 3'd7, 1, 8'h7F, 32'h20, 0, 0, 0, 0);

    // Single CALL/RET pair
    applyStimulus("call1", 0, 0, BR_CALL, 0, 8'h04, 32'h34,  1, 1, 0, 0);
    applyStimulus("ret1",  0, 0, BR_RET,  0, 8'h00, 32'h24,  1, 0, 0, 0);
    applyStimulus("jFar",  0, 0, BR_J,    0, 8'h36, 32'h100, 1, 0, 0, 0);

    // Five nested CALLs overflow a 4-deep stack
    applyStimulus("callA", 0, 0, BR_CALL, 0, 8'h3F, 32'h200, 1, 1, 0, 0);
    applyStimulus("callB", 0, 0, BR_CALL, 0, 8'h3F, 32'h300, 1, 2, 0, 0);
    applyStimulus("callC", 0, 0, BR_CALL, 0, 8'h3F, 32'h400, 1, 3, 0, 0);
    applyStimulus("callD", 0, 0, BR_CALL, 0, 8'h3F, 32'h500, 1, 4, 0, 0);
    applyStimulus("callE", 0, 0, BR_CALL, 0, 8'h3F, 32'h600, 1, 4, 1, 0);

    // Only the newest four return addresses survive
    applyStimulus("retA",     0, 0, BR_RET,  0, 8'h00, 32'h504, 1, 3, 1, 0);
    applyStimulus("retB",     0, 0, BR_RET,  0, 8'h00, 32'h404, 1, 2, 1, 0);
    applyStimulus("retC",     0, 0, BR_RET,  0, 8'h00, 32'h304, 1, 1, 1, 0);
    applyStimulus("retD",     0, 0, BR_RET,  0, 8'h00, 32'h204, 1, 0, 1, 0);
    applyStimulus("retEmpty", 0, 0, BR_RET,  0, 8'h00, 32'h208, 0, 0, 1, 1);
    applyStimulus("callStall",0, 1, BR_CALL, 0, 8'h3F, 32'h208, 0, 0, 1, 1);

    // Reset during a stall clears sticky flags
    applyStimulus("reset2", 1, 1, BR_CALL, 0, 8'h3F, 32'h0, 0, 0, 0, 0);

    // Address wrap-around in both directions
    applyStimulus("jWrap",   0, 0, BR_J,    0, 8'h80, 32'hFFFFFE04, 1, 0, 0, 0);
    applyStimulus("jToTop",  0, 0, BR_J,    0, 8'h7D, 32'hFFFFFFFC, 1, 0, 0, 0);
    applyStimulus("seqWrap", 0, 0, BR_NONE, 0, 8'h00, 32'h0,        0, 0, 0, 0);
    applyStimulus("jWrap2",  0, 0, BR_J,    0, 8'h80, 32'hFFFFFE04, 1, 0, 0, 0);

    // Fill three RAS entries, then reset mid-operation under busywait
    applyStimulus("callF", 0, 0, BR_CALL, 0, 8'h00, 32'hFFFFFE08, 1, 1, 0, 0);
    applyStimulus("callG", 0, 0, BR_CALL, 0, 8'h00, 32'hFFFFFE0C, 1, 2, 0, 0);
    applyStimulus("callH", 0, 0, BR_CALL, 0, 8'h00, 32'hFFFFFE10, 1, 3, 0, 0);
    applyStimulus("resetMid",  1, 1, BR_CALL, 0, 8'h00, 32'h0, 0, 0, 0, 0);
    applyStimulus("retAfterRst", 0, 0, BR_RET, 0, 8'h00, 32'h4, 0, 0, 0, 1);

    // Return inputs to idle and let the monitor drain, bounded
    @(negedge CLK);
    busywait = 1'b1;
    br_mode  = BR_NONE;
    for (int i = 0; i < 20 && expQ.size() != 0; i++) begin
      @(negedge CLK);
    end
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised next-generation PC update unit for the 8-bit processor datapath, driven by the control unit and the data-memory/cache busywait line.
- Holds the registered PC and computes next PC for sequential flow, BEQ, BNE, J, CALL and RET.
- A hardware return-address stack (RAS) supports CALL/RET.
- Stalls the PC and the RAS under busywait. All state updates in one clock domain.

Parameters:
- PC_WIDTH, 32, width of PC and all address arithmetic.
- OFFSET_WIDTH, 8, width of signed word offset from instruction.
- RAS_DEPTH, 4, number of RAS entries (power of two, >=2).
- RESET_VECTOR, 0, PC value after reset (word aligned).

Ports:
- CLK  in  1  system clock, all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset; sampled on rising CLK edge; overrides every other input.
- busywait  in  1  memory stall; when 1, no state changes.
- br_mode  in  3  NONE=0, BEQ=1, BNE=2, J=3, CALL=4, RET=5; 6/7 treated as NONE.
- zero  in  1  ALU zero flag for BEQ/BNE.
- offset  in  OFFSET_WIDTH  signed word offset.
- pc  out  PC_WIDTH  current PC (registered).
- pc_plus4  out  PC_WIDTH  pc+4 (combinational).
- redirect  out  1  registered; 1 for one cycle after a non-sequential PC load.
- ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_overflow  out  1  sticky; set on CALL with RAS full.
- ras_underflow  out  1  sticky; set on RET with RAS empty.

Behaviour:
- Reset (RESET=1 at an edge):
  - pc=RESET_VECTOR, redirect=0, ras_count=0, both sticky flags 0, RAS pointer 0.
  - RESET wins over busywait.
- Advance rule: state advances only on an edge with RESET=0 and busywait=0. Otherwise pc, RAS, flags and redirect hold.
- Latency: next PC is visible on pc one edge after inputs are sampled.
- Arithmetic:
  - target = pc_plus4 + (sign_extend(offset) << 2).
  - All sums are modulo 2^PC_WIDTH; wrap-around is legal and silent.
- Next-PC selection per br_mode:
  - NONE: pc_plus4.
  - BEQ: target if zero=1, else pc_plus4.
  - BNE: target if zero=0, else pc_plus4.
  - J: target.
  - CALL: target; push pc_plus4.
  - RET, non-empty RAS: pop top; pc=popped value.
  - RET, empty RAS: pc=pc_plus4; set ras_underflow.
- redirect: next value is 1 when the selected PC differs in source from pc_plus4 (taken branch, J, CALL, successful RET), else 0.
- RAS is a circular LIFO:
  - Push on full: overwrite the oldest entry, ras_count stays RAS_DEPTH, set ras_overflow.
  - Pops after an overflow return the newest RAS_DEPTH addresses only.
- Sticky flags clear only on RESET.
- No read-during-write hazard: a single br_mode per cycle, so push and pop are never simultaneous.

Decomposition:
- Shared package pc_seq_pkg: br_mode encodings (BR_NONE..BR_RET) and the mode width constant.
- Sub-module pc_ras: the return-address stack.
  - Parameters: PC_WIDTH, RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, count, empty, full.
  - Same CLK/RESET.
- Sign-extend/shift/add stays inline in pc_sequencer.

Test Plan (PC_WIDTH=32, OFFSET_WIDTH=8, RAS_DEPTH=4, RESET_VECTOR=0):
- Sequential flow: RESET high 1 edge, then br_mode=NONE for 3 edges -> pc 0x0, 0x4, 0x8, 0xC; redirect=0 throughout.
- Conditional branches:
  - At pc=0x8, BEQ, zero=1, offset=0xFE -> pc=0x4, redirect=1 next cycle.
  - Repeat at 0x8 with zero=0 -> pc=0xC.
  - BNE, zero=0, offset=0x02 at 0x8 -> pc=0x14.
- Stall: at pc=0xC, J offset=0x03 with busywait=1 for 3 edges -> pc holds 0xC, redirect=0; busywait drops -> pc=0x1C.
- Return-address stack:
  - CALL at 0x20, offset=0x04 -> pc=0x34, ras_count=1; RET -> pc=0x24, ras_count=0.
  - 5 CALLs from 0x100, 0x200, 0x300, 0x400, 0x500 -> ras_overflow=1, ras_count=4.
  - 4 RETs -> pc=0x504, 0x404, 0x304, 0x204; 5th RET -> pc=previous pc+4, ras_underflow=1.
- Wrap-around:
  - pc=0xFFFFFFFC, NONE -> pc=0x0.
  - At pc=0x0, J offset=0x80 -> pc=0xFFFFFE04.
- Reset mid-operation: RAS count=3, busywait=1, RESET=1 -> next edge pc=0x0, ras_count=0, flags 0, redirect=0.
